// File: rtl/gpr_writeback.sv
// Writeback stage: arbitrates EXU/LSU results into an in-order FIFO and retires one GPR write per cycle.
// Optional macro GPR_WB_FWD_EN adds combinational forwarding ports that read the buffered entries.
module gpr_writeback #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            gpr_ready,
  output logic            gpr_we,
  output logic [4:0]      gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            wb_commit,
  output logic [4:0]      wb_commit_rd,
  output logic            wb_empty
`ifdef GPR_WB_FWD_EN
  ,
  input  logic [4:0]      fwd_rs1,
  input  logic [4:0]      fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2
`endif
);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]      rd_mem_q   [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic            full;
  logic            empty;
  logic            push_lsu;
  logic            push_exu;
  logic            push;
  logic            pop;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // LSU has fixed priority; readies never look at gpr_ready.
  assign lsu_ready = !full;
  assign exu_ready = !full && !lsu_valid;

  assign push_lsu  = lsu_valid && lsu_ready;
  assign push_exu  = exu_valid && exu_ready;
  assign push      = push_lsu || push_exu;
  assign push_rd   = push_lsu ? lsu_rd   : exu_rd;
  assign push_data = push_lsu ? lsu_data : exu_data;

  assign head_rd   = empty ? 5'd0      : rd_mem_q[rptr_q];
  assign head_data = empty ? {XLEN{1'b0}} : data_mem_q[rptr_q];

  // Pop is suppressed while reset is asserted so nothing retires in the reset cycle.
  assign pop = !empty && gpr_ready && rst;

  assign gpr_we       = pop && (head_rd != 5'd0);
  assign gpr_waddr    = head_rd;
  assign gpr_wdata    = head_data;
  assign wb_commit    = pop;
  assign wb_commit_rd = head_rd;
  assign wb_empty     = empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= push_rd;
      data_mem_q[wptr_q] <= push_data;
    end
  end

`ifdef GPR_WB_FWD_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((fwd_rs1 != 5'd0) && (rd_mem_q[idx] == fwd_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem_q[idx];
        end
        if ((fwd_rs2 != 5'd0) && (rd_mem_q[idx] == fwd_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem_q[idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed self-checking bench for gpr_writeback (DEPTH=2, XLEN=32).
module tb_gpr_writeback;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        gpr_ready;
  logic        gpr_we;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        wb_commit;
  logic [4:0]  wb_commit_rd;
  logic        wb_empty;
`ifdef GPR_WB_FWD_EN
  logic [4:0]  fwd_rs1;
  logic [4:0]  fwd_rs2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gpr_writeback #(.DEPTH(2), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .exu_valid    (exu_valid),
    .exu_ready    (exu_ready),
    .exu_rd       (exu_rd),
    .exu_data     (exu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .gpr_ready    (gpr_ready),
    .gpr_we       (gpr_we),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .wb_commit    (wb_commit),
    .wb_commit_rd (wb_commit_rd),
    .wb_empty     (wb_empty)
`ifdef GPR_WB_FWD_EN
    ,
    .fwd_rs1      (fwd_rs1),
    .fwd_rs2      (fwd_rs2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL rst_gpr_we: got %h want 0", gpr_we); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL rst_commit: got %h want 0", wb_commit); end
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %h want 1", wb_empty); end
    n_cmp++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL rst_exu_ready: got %h want 1", exu_ready); end
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL rst_lsu_ready: got %h want 1", lsu_ready); end
    n_cmp++; if (gpr_waddr !== 5'd0) begin n_err++; $display("FAIL rst_waddr: got %h want 0", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", gpr_wdata); end
    n_cmp++; if (wb_commit_rd !== 5'd0) begin n_err++; $display("FAIL rst_commit_rd: got %h want 0", wb_commit_rd); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_exu;
    gpr_ready = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
    @(negedge clk);
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL single_no_bypass: got %h want 0", gpr_we); end
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL single_we: got %h want 1", gpr_we); end
    n_cmp++; if (gpr_waddr !== 5'd5) begin n_err++; $display("FAIL single_waddr: got %h want 5", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'h1234) begin n_err++; $display("FAIL single_wdata: got %h want 1234", gpr_wdata); end
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL single_commit: got %h want 1", wb_commit); end
    n_cmp++; if (wb_commit_rd !== 5'd5) begin n_err++; $display("FAIL single_commit_rd: got %h want 5", wb_commit_rd); end
    tick();
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL single_empty_after: got %h want 1", wb_empty); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL single_commit_after: got %h want 0", wb_commit); end
  endtask

  task automatic test_arbitration;
    gpr_ready = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB;
    @(negedge clk);
    n_cmp++; if (exu_ready !== 1'b0) begin n_err++; $display("FAIL arb_exu_ready: got %h want 0", exu_ready); end
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL arb_lsu_ready: got %h want 1", lsu_ready); end
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL arb_exu_ready2: got %h want 1", exu_ready); end
    n_cmp++; if (gpr_waddr !== 5'd4) begin n_err++; $display("FAIL arb_first_waddr: got %h want 4", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'hB) begin n_err++; $display("FAIL arb_first_wdata: got %h want b", gpr_wdata); end
    n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL arb_first_we: got %h want 1", gpr_we); end
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (gpr_waddr !== 5'd3) begin n_err++; $display("FAIL arb_second_waddr: got %h want 3", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'hA) begin n_err++; $display("FAIL arb_second_wdata: got %h want a", gpr_wdata); end
    n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL arb_second_we: got %h want 1", gpr_we); end
    tick();
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL arb_empty: got %h want 1", wb_empty); end
  endtask

  task automatic test_full_stall;
    gpr_ready = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd10; exu_data = 32'h100;
    tick();
    exu_rd = 5'd11; exu_data = 32'h200;
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL full_lsu_ready: got %h want 0", lsu_ready); end
    n_cmp++; if (exu_ready !== 1'b0) begin n_err++; $display("FAIL full_exu_ready: got %h want 0", exu_ready); end
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL full_we: got %h want 0", gpr_we); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL full_commit: got %h want 0", wb_commit); end
    n_cmp++; if (gpr_waddr !== 5'd10) begin n_err++; $display("FAIL full_head_held: got %h want a", gpr_waddr); end
    // Offer an LSU result while full; it must not be taken.
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h999;
    tick();
    gpr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL drain1_we: got %h want 1", gpr_we); end
    n_cmp++; if (gpr_waddr !== 5'd10) begin n_err++; $display("FAIL drain1_waddr: got %h want a", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'h100) begin n_err++; $display("FAIL drain1_wdata: got %h want 100", gpr_wdata); end
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL drain1_ready_still_low: got %h want 0", lsu_ready); end
    lsu_valid = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL drain2_lsu_ready: got %h want 1", lsu_ready); end
    n_cmp++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL drain2_exu_ready: got %h want 1", exu_ready); end
    n_cmp++; if (gpr_waddr !== 5'd11) begin n_err++; $display("FAIL drain2_waddr: got %h want b", gpr_waddr); end
    n_cmp++; if (gpr_wdata !== 32'h200) begin n_err++; $display("FAIL drain2_wdata: got %h want 200", gpr_wdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %h want 1", wb_empty); end
  endtask

  task automatic test_rd_zero;
    gpr_ready = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hDEAD;
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (wb_commit !== 1'b1) begin n_err++; $display("FAIL rd0_commit: got %h want 1", wb_commit); end
    n_cmp++; if (wb_commit_rd !== 5'd0) begin n_err++; $display("FAIL rd0_commit_rd: got %h want 0", wb_commit_rd); end
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL rd0_we: got %h want 0", gpr_we); end
    n_cmp++; if (gpr_wdata !== 32'hDEAD) begin n_err++; $display("FAIL rd0_wdata: got %h want dead", gpr_wdata); end
    tick();
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL rd0_empty: got %h want 1", wb_empty); end
  endtask

  task automatic test_back_to_back;
    gpr_ready = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        exu_valid = 1'b1; exu_rd = 5'(k + 1); exu_data = 32'h50 + 32'(k);
      end else begin
        exu_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL b2b_we[%0d]: got %h want 1", k, gpr_we); end
        n_cmp++; if (gpr_waddr !== 5'(k)) begin n_err++; $display("FAIL b2b_waddr[%0d]: got %0d want %0d", k, gpr_waddr, k); end
        n_cmp++; if (gpr_wdata !== 32'h50 + 32'(k - 1)) begin n_err++; $display("FAIL b2b_wdata[%0d]: got %h want %h", k, gpr_wdata, 32'h50 + 32'(k - 1)); end
      end
      if (k < 6) begin
        n_cmp++; if (exu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %h want 1", k, exu_ready); end
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %h want 1", wb_empty); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL b2b_no_extra: got %h want 0", wb_commit); end
  endtask

`ifdef GPR_WB_FWD_EN
  task automatic test_forward;
    gpr_ready = 1'b0;
    fwd_rs1 = 5'd7; fwd_rs2 = 5'd0;
    @(negedge clk);
    n_cmp++; if (fwd_hit1 !== 1'b0) begin n_err++; $display("FAIL fwd_empty_hit: got %h want 0", fwd_hit1); end
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h1;
    tick();
    exu_data = 32'h2;
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (fwd_hit1 !== 1'b1) begin n_err++; $display("FAIL fwd_hit1: got %h want 1", fwd_hit1); end
    n_cmp++; if (fwd_data1 !== 32'h2) begin n_err++; $display("FAIL fwd_data1_youngest: got %h want 2", fwd_data1); end
    n_cmp++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_hit2_rs0: got %h want 0", fwd_hit2); end
    n_cmp++; if (fwd_data2 !== 32'h0) begin n_err++; $display("FAIL fwd_data2_rs0: got %h want 0", fwd_data2); end
    fwd_rs2 = 5'd9;
    @(negedge clk);
    n_cmp++; if (fwd_hit2 !== 1'b0) begin n_err++; $display("FAIL fwd_hit2_miss: got %h want 0", fwd_hit2); end
    gpr_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL fwd_drain_empty: got %h want 1", wb_empty); end
    fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
  endtask
`endif

  task automatic test_reset_mid;
    gpr_ready = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC0;
    tick();
    lsu_rd = 5'd13; lsu_data = 32'hC1;
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL midrst_full: got %h want 0", lsu_ready); end
    rst = 1'b0;
    gpr_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL midrst_no_write: got %h want 0", gpr_we); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (wb_empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %h want 1", wb_empty); end
    n_cmp++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %h want 0", gpr_we); end
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %h want 1", lsu_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (wb_commit !== 1'b0) begin n_err++; $display("FAIL midrst_no_commit: got %h want 0", wb_commit); end
  endtask

  initial begin
    rst = 1'b0;
    exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    gpr_ready = 1'b0;
`ifdef GPR_WB_FWD_EN
    fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
`endif
    #1;
    test_reset();
    test_single_exu();
    test_arbitration();
    test_full_stall();
    test_rd_zero();
    test_back_to_back();
`ifdef GPR_WB_FWD_EN
    test_forward();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
- Writeback stage: the producer side of the general-purpose register file write port (write-enable, destination index, write data).
- Accepts results from two sources, EXU (ALU) and LSU (load data), each over a valid/ready handshake.
- Arbitrates between them, buffers results in a small in-order FIFO, and retires one register write per cycle when the register file signals ready.
- Emits a per-retirement commit pulse for the pipeline control.

Parameters:
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset: the block resets on a clk edge where rst==0.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  5  EXU destination register.
- exu_data  in  XLEN  EXU result.
- lsu_valid  in  1  LSU result valid.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  XLEN  load result.
- gpr_ready  in  1  register file can take a write this cycle.
- gpr_we  out  1  register write enable.
- gpr_waddr  out  5  register write index.
- gpr_wdata  out  XLEN  register write data.
- wb_commit  out  1  one-cycle pulse per retired entry, including rd==0 entries.
- wb_commit_rd  out  5  rd of the retired entry.
- wb_empty  out  1  FIFO empty.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Read pointer, write pointer and count go to 0.
  - FIFO contents are don't-care.
  - All outputs after reset: gpr_we=0, wb_commit=0, wb_empty=1, exu_ready=1, lsu_ready=1, gpr_waddr=0, gpr_wdata=0, wb_commit_rd=0.
  - Head fields read as 0 when the FIFO is empty.
  - Reset mid-operation discards all buffered entries; no write occurs in the reset cycle.
- full = (count==DEPTH); empty = (count==0).
- Arbitration: at most one push per cycle; LSU has fixed priority.
  - lsu_ready = !full.
  - exu_ready = !full & !lsu_valid.
  - The ready outputs depend only on registered state and lsu_valid, never on gpr_ready.
- Push: on a clk edge with (lsu_valid&lsu_ready) or (exu_valid&exu_ready), the selected {rd,data} is written at the write pointer, and the write pointer increments modulo DEPTH (wraps).
- Pop condition: pop = !empty & gpr_ready.
- Outputs driven combinationally from the FIFO head entry:
  - gpr_we = pop & (head.rd != 0).
  - gpr_waddr = head.rd, gpr_wdata = head.data.
  - wb_commit = pop, wb_commit_rd = head.rd.
- On a clk edge with pop, the read pointer increments modulo DEPTH.
- Latency: a result accepted at edge N appears on the write port in cycle N+1, i.e. it is written into the register file at edge N+1 if gpr_ready=1. No same-cycle bypass from input to output.
- rd==0 entries occupy a slot and produce wb_commit but never assert gpr_we.
- Push and pop in the same edge: count is unchanged and both pointers advance. This is legal at every count except full, where a push is impossible because ready is low.
- Ordering: strict FIFO order. Within one source, writes retire in acceptance order. Across sources, order is the acceptance order.
- gpr_ready=0: head is held stable, gpr_we=0, wb_commit=0; the FIFO may continue filling up to full.
- Handshake rule: a source whose valid is high while its ready is low must hold rd/data stable; the block does not latch it.

Optional Feature:
- Macro GPR_WB_FWD_EN.
- Defined, extra ports:
  - fwd_rs1, fwd_rs2 in 5.
  - fwd_hit1, fwd_hit2 out 1.
  - fwd_data1, fwd_data2 out XLEN.
- Forwarding rule: a hit occurs when a valid FIFO entry has rd == rs and rs != 0.
- Data selection: data comes from the youngest matching entry (nearest the write pointer).
- The forwarding path is purely combinational from FIFO state; hit=0 and data=0 when there is no match.
- Undefined: the ports are absent and no comparators are built.

Test Plan:
- Reset then idle, rst=0 for 2 cycles -> gpr_we=0, wb_empty=1, exu_ready=lsu_ready=1.
- Single EXU push, rd=5, data=0x1234 at edge N, gpr_ready=1 -> cycle N+1: gpr_we=1, waddr=5, wdata=0x1234, wb_commit=1; cycle N+2: wb_empty=1.
- Simultaneous exu_valid (rd=3, 0xA) and lsu_valid (rd=4, 0xB) with the FIFO empty:
  - LSU accepted first (exu_ready=0 that cycle).
  - Retire order: rd=4/0xB, then rd=3/0xA.
- gpr_ready=0 while pushing 2 entries (DEPTH=2) -> full, both readies 0, gpr_we=0. Raise gpr_ready -> entries retire in order, one per cycle; readies return to 1 after the first pop.
- Push rd=0, data=0xDEAD -> wb_commit=1 with wb_commit_rd=0, gpr_we=0.
- With DEPTH=2, sustain 6 back-to-back pushes with gpr_ready=1 (pointer wrap) -> 6 writes in order, none lost or duplicated.
- With GPR_WB_FWD_EN: gpr_ready=0, FIFO holds rd=7/0x1 then rd=7/0x2; set fwd_rs1=7 -> fwd_hit1=1, fwd_data1=0x2. Set fwd_rs2=0 -> fwd_hit2=0.
- Reset mid-operation: rst=0 while the FIFO is full -> next cycle wb_empty=1, and no writes retire afterwards.
